// File: rtl/data_memory_responder.sv
// Purpose: enable/busy handshake responder backed by a byte-addressed 64-bit word RAM with byte-lane writes.
// Latency: busy is high for BUSY_CYCLES edges after the request edge; read_data updates on the edge busy falls.
// Backpressure: busy holds off the initiator; a completed access waits in DONE until enable drops.
module data_memory_responder #(
  parameter int ADDR_SIZE   = 11,
  parameter int BUSY_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ADDR_SIZE-1:0] address,
  input  logic [7:0]           byte_write_enable,
  input  logic [63:0]          write_data,
  output logic                 busy,
  output logic [63:0]          read_data
);

  localparam int WORDS = 1 << (ADDR_SIZE - 3);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]           state;
  logic [7:0]           counter;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [7:0]           mask_q;
  logic [63:0]          wdata_q;

  logic [63:0] mem [WORDS];

  logic [ADDR_SIZE-4:0] word_idx;
  logic [2:0]           lane_off;
  logic [7:0]           eff_mask;
  logic [63:0]          eff_data;
  logic [63:0]          rd_shifted;
  logic                 last_cycle;
  logic                 mem_we;

  // Lane alignment: shift lane-0 relative mask/data up to the addressed lane; bytes past lane 7 fall off.
  always_comb begin
    word_idx   = addr_q[ADDR_SIZE-1:3];
    lane_off   = addr_q[2:0];
    eff_mask   = mask_q << lane_off;
    eff_data   = wdata_q << {lane_off, 3'b000};
    rd_shifted = mem[word_idx] >> {lane_off, 3'b000};
    last_cycle = (state == ACCESS) && (counter == 8'd0);
    mem_we     = last_cycle && (mask_q != 8'd0);
  end

  // Handshake FSM: capture the request, count out the busy window, then wait for enable to drop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 8'd0;
      busy      <= 1'b0;
      read_data <= 64'd0;
      addr_q    <= '0;
      mask_q    <= 8'd0;
      wdata_q   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            addr_q  <= address;
            mask_q  <= byte_write_enable;
            wdata_q <= write_data;
            counter <= 8'(BUSY_CYCLES - 1);
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Inputs are ignored here: once accepted, an access always runs to completion.
          if (counter != 8'd0) begin
            counter <= counter - 8'd1;
          end else begin
            if (mask_q == 8'd0) begin
              read_data <= rd_shifted;
            end
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Hold here until the initiator releases enable so a lingering enable cannot re-trigger.
          if (!enable) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage write port: only the lanes selected by the aligned mask are updated; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (eff_mask[i]) begin
          mem[word_idx][8*i +: 8] <= eff_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int AS = 11;
  localparam int BC = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [AS-1:0] address;
  logic [7:0]    byte_write_enable;
  logic [63:0]   write_data;
  logic          busy;
  logic [63:0]   read_data;

  int checks   = 0;
  int failures = 0;

  // Byte-level reference memory: address a holds one byte, no word structure.
  logic [7:0] mbyte [0:(1<<AS)-1];

  data_memory_responder #(.ADDR_SIZE(AS), .BUSY_CYCLES(BC)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .address           (address),
    .byte_write_enable (byte_write_enable),
    .write_data        (write_data),
    .busy              (busy),
    .read_data         (read_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference read: bytes from the address up to the end of its word, zero above.
  function automatic logic [63:0] model_read(input logic [AS-1:0] a);
    logic [63:0] r;
    int off;
    r   = 64'd0;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++)
      if (off + i < 8) r[8*i +: 8] = mbyte[int'(a) + i];
    return r;
  endfunction

  task automatic model_write(input logic [AS-1:0] a, input logic [7:0] m, input logic [63:0] d);
    int off;
    off = int'(a[2:0]);
    for (int i = 0; i < 8; i++)
      if (m[i] && (off + i < 8)) mbyte[int'(a) + i] = d[8*i +: 8];
  endtask

  // One full handshake; inputs are scrambled during ACCESS to show they are ignored.
  task automatic do_access(input logic [AS-1:0] a, input logic [7:0] m, input logic [63:0] d,
                           input bit drop_early, input int hold, output logic [63:0] rd);
    logic [63:0] exp_rd;
    logic [63:0] prev_rd;
    int n;
    int hi;
    exp_rd  = model_read(a);
    prev_rd = read_data;
    @(negedge clock);
    enable = 1'b1; address = a; byte_write_enable = m; write_data = d;
    @(posedge clock); #1;
    chk("busy_rise", busy, 1);
    n = 0;
    while (busy && n < 300) begin
      n++;
      if (n == 1) begin
        @(negedge clock);
        enable            = drop_early ? 1'b0 : 1'b1;
        address           = AS'($urandom);
        byte_write_enable = 8'($urandom);
        write_data        = {$urandom, $urandom};
      end
      @(posedge clock); #1;
    end
    chk("busy_len", 64'(n), 64'(BC));
    rd = read_data;
    if (m == 8'd0) chk("read_data", read_data, exp_rd);
    else begin
      chk("wr_keeps_rdata", read_data, prev_rd);
      model_write(a, m, d);
    end
    hi = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      if (busy) hi++;
    end
    if (hold > 0) chk("no_retrigger", 64'(hi), 64'd0);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [63:0] rd;
    logic [AS-1:0] ra;
    logic [7:0] rm;
    int n;

    // Reset held with enable high.
    reset = 1'b0; enable = 1'b1; address = '0; byte_write_enable = 8'd0; write_data = 64'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rdata", read_data, 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("busy_first_edge", busy, 1);
    n = 0;
    while (busy && n < 300) begin n++; @(posedge clock); #1; end
    chk("reset_first_len", 64'(n), 64'(BC));
    @(negedge clock); enable = 1'b0;
    @(posedge clock); #1;

    // Give the low 32 words a known value so every later read is predictable.
    for (int w = 0; w < 32; w++) do_access(AS'(w * 8), 8'hFF, 64'd0, 1'b0, 0, rd);

    // SD then LD.
    do_access(11'h010, 8'hFF, 64'h1122334455667788, 1'b0, 0, rd);
    do_access(11'h010, 8'h00, 64'd0, 1'b0, 0, rd);
    chk("sd_ld", rd, 64'h1122334455667788);

    // SB at offset 3, then offset read and full-word read.
    do_access(11'h013, 8'h01, 64'h00000000000000AB, 1'b0, 0, rd);
    do_access(11'h013, 8'h00, 64'd0, 1'b0, 0, rd);
    chk("sb_off_read", rd, 64'h00000011223344AB);
    do_access(11'h010, 8'h00, 64'd0, 1'b0, 0, rd);
    chk("sb_word", rd, 64'h11223344AB667788);

    // SW at offset 6 loses its upper two bytes.
    do_access(11'h016, 8'h0F, 64'h00000000DEADBEEF, 1'b0, 0, rd);
    do_access(11'h010, 8'h00, 64'd0, 1'b0, 0, rd);
    chk("trunc_sw", rd, 64'hBEEF3344AB667788);

    // Enable held for 10 cycles gives one busy pulse.
    do_access(11'h010, 8'h00, 64'd0, 1'b0, 10 - BC - 1, rd);
    chk("hold_read", rd, 64'hBEEF3344AB667788);

    // Enable dropped during ACCESS: write still lands.
    do_access(11'h030, 8'hFF, 64'hCAFEF00D12345678, 1'b1, 0, rd);
    do_access(11'h030, 8'h00, 64'd0, 1'b0, 0, rd);
    chk("drop_write", rd, 64'hCAFEF00D12345678);

    // Reset during an SD to 0x20 aborts it without writing.
    @(negedge clock);
    enable = 1'b1; address = 11'h020; byte_write_enable = 8'hFF; write_data = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clock); #1;
    chk("midrst_busy_hi", busy, 1);
    @(negedge clock);
    reset = 1'b0; enable = 1'b0;
    #1;
    chk("midrst_busy_lo", busy, 0);
    chk("midrst_rdata", read_data, 0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_idle", busy, 0);
    do_access(11'h020, 8'h00, 64'd0, 1'b0, 0, rd);
    chk("midrst_nowrite", rd, 64'd0);

    // Randomized mix over the initialized region.
    for (int t = 0; t < 200; t++) begin
      ra = AS'($urandom_range(0, 255));
      rm = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
      do_access(ra, rm, {$urandom, $urandom}, bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 2 : 0, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Memory-side responder for the core's enable/busy memory handshake. The control unit acts as initiator: it raises enable, waits for busy to rise, then waits for busy to fall. This block answers those requests with a fixed-latency, byte-addressed, 64-bit word RAM that supports byte-lane write enables. It sits between the control unit/datapath and on-chip storage, and serves as the data memory (or as the instruction memory, with byte_write_enable tied to 0).

Parameters:
ADDR_SIZE, 11, byte-address width; memory holds 2^(ADDR_SIZE-3) 64-bit words.
BUSY_CYCLES, 3, cycles busy stays high per access; legal range 1..255.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
enable  input  1  access request from initiator
address  input  ADDR_SIZE  byte address; [ADDR_SIZE-1:3] = word index, [2:0] = lane offset
byte_write_enable  input  8  byte-lane mask, lane-0 relative; 0 = read, non-zero = write
write_data  input  64  store data, lane-0 relative (SB data in [7:0])
busy  output  1  high while an access is in progress
read_data  output  64  load result, shifted down to lane 0

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, read_data=0, counter=0. Memory array is not cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - busy=0.
  - On a rising edge with enable=1, capture address, byte_write_enable and write_data into registers.
  - Load counter with BUSY_CYCLES-1, set busy<=1, go to ACCESS.
- ACCESS:
  - busy=1.
  - All inputs are ignored, including enable dropping; there is no abort.
  - counter!=0: decrement.
  - counter==0, write (mask!=0): write the selected bytes, busy<=0, go to DONE. read_data is unchanged.
  - counter==0, read (mask==0): set read_data <= word >> (8*offset), zero-filled from the top; busy<=0; go to DONE.
- DONE:
  - busy=0; read_data holds its value.
  - Stay in DONE while enable=1; enable=0 returns to IDLE.
  - A new request therefore needs enable low for at least 1 cycle. This prevents a re-trigger while the initiator is still dropping enable.
- Latency:
  - Request sampled at edge E0.
  - busy is high from E0 until edge E0+BUSY_CYCLES.
  - read_data is valid from the same edge at which busy falls.
  - With enable dropped right away, minimum period between accesses is BUSY_CYCLES+2 cycles.
- Lane alignment:
  - Effective mask = (byte_write_enable << offset) truncated to 8 bits.
  - Effective data = write_data << (8*offset), truncated to 64 bits.
  - Bytes shifted past lane 7 are dropped. Word-crossing accesses are not supported and are silently truncated.
- Reads return unextended bytes. Sign/zero extension belongs to the datapath.
- Reset mid-access: no memory write occurs, busy=0 immediately, state=IDLE.
- Address bits above the array size do not exist (the address width is exact), so no wrap logic is needed.

Test Plan:
- Reset: hold reset=0 for 2 cycles with enable=1 -> busy=0, read_data=0; after release, busy rises on the first edge.
- SD then LD: write addr 0x10, mask 0xFF, data 0x1122334455667788, then read 0x10 with mask 0x00 -> read_data=0x1122334455667788. busy is high exactly 3 cycles per access; read_data is valid on the edge busy falls.
- SB plus offset read: write addr 0x13, mask 0x01, data 0xAB -> word becomes 0x11223344AB667788. Read addr 0x13 -> read_data=0x00000011223344AB.
- Truncated SW: write addr 0x16, mask 0x0F, data 0xDEADBEEF -> word at 0x10 becomes 0xBEEF3344AB667788 (0xDE and 0xAD are dropped).
- Handshake: hold enable=1 for 10 cycles -> exactly one busy pulse. Drop enable during ACCESS -> busy still completes 3 cycles and the write still lands.
- Reset mid-write: during ACCESS of an SD to 0x20 (prior value 0x0), pulse reset=0 -> busy=0 at once. A subsequent read of 0x20 returns 0x0.
